mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one external SRAM-like bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the datapath.
- Raises stallreq_from_if / stallreq_from_mem until each port's transaction completes.
- Holds completed read data until the pipeline advances, so a fetch or load is never re-issued while the pipeline stalls for something else.
- Data port has fixed priority over instruction port.

Parameters:
- INST_SIZE, 2'b10, bus_size_o value driven for instruction fetches (word).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- inst_req_i  in  1  IF wants an instruction at inst_addr_i
- inst_addr_i  in  32  fetch address (if_pc)
- inst_rdata_o  out  32  fetched instruction (if_instr)
- stallreq_from_if_o  out  1  fetch not yet complete
- data_en_i  in  1  MEM-stage access; already exception-qualified by the datapath
- data_we_i  in  1  1 = store
- data_sel_i  in  4  byte enables
- data_size_i  in  2  0 = byte, 1 = half, 2 = word
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data
- stallreq_from_mem_o  out  1  data access not yet complete
- pipe_advance_i  in  1  pipeline moves this cycle (no global stall)
- flush_i  in  1  exception/eret flush
- bus_req_o  out  1  request valid
- bus_wr_o  out  1  write request
- bus_size_o  out  2  access size
- bus_addr_o  out  32  address
- bus_wdata_o  out  32  write data
- bus_wstrb_o  out  4  write strobes
- bus_addr_ok_i  in  1  request accepted
- bus_data_ok_i  in  1  response valid
- bus_rdata_i  in  32  response data
- perf_if_stall_o  out  32  see Optional Feature
- perf_mem_stall_o  out  32  see Optional Feature

Behaviour:
- Registers: state, inst_done, data_done, inst_discard, inst_buf, data_buf, latched request fields.
- Reset: state = IDLE; all flags 0; inst_rdata_o = data_rdata_o = 0; bus_req_o = bus_wr_o = 0; bus_addr_o = bus_wdata_o = bus_wstrb_o = 0; bus_size_o = 0; perf counters = 0.
- Reset mid-transaction abandons the transaction; the bus is reset by the same rst_i.
- Pending conditions:
  - d_pend = data_en_i & ~data_done
  - i_pend = inst_req_i & ~inst_done
- stallreq_from_mem_o = d_pend; stallreq_from_if_o = i_pend. Both combinational.
- IDLE:
  - d_pend → D_ADDR (latch data_* fields).
  - Else i_pend → I_ADDR (latch inst_addr_i).
  - Simultaneous requests: data wins.
- D_ADDR / I_ADDR:
  - bus_req_o = 1 with latched fields.
  - Instruction requests: bus_wr_o = 0, bus_wstrb_o = 0, bus_size_o = INST_SIZE.
  - Data requests: bus_wr_o = data_we, bus_wstrb_o = we ? sel : 0, bus_size_o = data_size.
  - Request stays stable until bus_addr_ok_i, then go to D_WAIT / I_WAIT. A request is never withdrawn.
- D_WAIT / I_WAIT:
  - bus_req_o = 0.
  - On bus_data_ok_i: capture bus_rdata_i into data_buf / inst_buf, set data_done / inst_done, go to IDLE.
  - I_WAIT with inst_discard = 1: drop the data, clear inst_discard, leave inst_done = 0, go to IDLE.
- Bus contract: bus_data_ok_i arrives at least 1 cycle after bus_addr_ok_i. Responses arrive in order with only one outstanding request.
- Minimum stall: request in cycle 0 (IDLE), bus_req_o in cycle 1 with addr_ok, data_ok in cycle 2, stall low in cycle 3.
- pipe_advance_i = 1 clears inst_done and data_done at the clock edge.
- flush_i = 1:
  - Clears inst_done and data_done.
  - In I_ADDR or I_WAIT, sets inst_discard. The in-flight fetch still completes on the bus, and the new PC is fetched afterwards.
  - Data transactions always complete; a flush only clears data_done.
- flush_i and bus_data_ok_i in the same cycle in I_WAIT: the data is discarded.
- Because data_done is held, an instruction fetch that is pending behind a completed data access is served next. No starvation.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined: perf_if_stall_o / perf_mem_stall_o increment each cycle stallreq_from_if_o / stallreq_from_mem_o is 1. Counters wrap modulo 2^32 and clear on rst_i.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Fetch only, inst_addr 0xBFC00000, addr_ok in the first request cycle, data_ok 1 cycle later with 0x24010001 → stallreq_from_if high exactly cycles 0-2, inst_rdata_o = 0x24010001 from cycle 3.
- Same-cycle fetch 0xBFC00010 and load 0x80000100 → bus sees the load first (bus_wr_o = 0, size 2), then the fetch; stallreq_from_mem drops before stallreq_from_if.
- Byte store sel = 4'b0100, data 0x00AB0000, addr_ok delayed 3 cycles → bus_req_o and all fields stable for 4 cycles, bus_wstrb_o = 4'b0100, bus_wr_o = 1.
- flush_i during I_WAIT, data_ok returns 0xDEADBEEF, new fetch 0xBFC00380 returns 0x00000000 → 0xDEADBEEF never appears on inst_rdata_o, second request addr 0xBFC00380.
- Fetch done and pipe_advance_i held 0 for 5 cycles → no second bus request, inst_rdata_o held. Then pipe_advance_i = 1 → next fetch issued.
- With ARB_PERF_EN, 7 total IF stall cycles → perf_if_stall_o = 7. rst_i asserted in D_WAIT → state IDLE, outputs at reset values the next cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one SRAM-like bus between the instruction-fetch port
//               and the data port. The data port has fixed priority. Completed
//               read data is held until the pipeline advances, so a fetch or
//               load is never re-issued while the pipeline is stalled.
//               Optional macro ARB_PERF_EN adds 32-bit stall-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter logic [1:0] INST_SIZE = 2'b10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction port
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        stallreq_from_if_o,
    // data port
    input  logic        data_en_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        stallreq_from_mem_o,
    // pipeline control
    input  logic        pipe_advance_i,
    input  logic        flush_i,
    // external bus
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i,
    // performance counters
    output logic [31:0] perf_if_stall_o,
    output logic [31:0] perf_mem_stall_o
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_D_ADDR = 3'd1;
    localparam logic [2:0] c_ST_D_WAIT = 3'd2;
    localparam logic [2:0] c_ST_I_ADDR = 3'd3;
    localparam logic [2:0] c_ST_I_WAIT = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic        r_inst_done;
    logic        r_data_done;
    logic        r_inst_discard;
    logic [31:0] r_inst_buf;
    logic [31:0] r_data_buf;

    // request fields latched when a transaction starts
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wr;
    logic [1:0]  r_size;

    logic        w_d_pend;
    logic        w_i_pend;
    logic        w_start_data;
    logic        w_start_inst;
    logic        w_data_resp;
    logic        w_inst_resp;
    logic        w_inst_keep;
    logic        w_inst_in_flight;

    assign w_d_pend = data_en_i & ~r_data_done;
    assign w_i_pend = inst_req_i & ~r_inst_done;

    // A fetch is not started in the flush cycle: inst_addr_i still carries the
    // squashed PC then, and the redirected PC shows up one cycle later.
    assign w_start_data = (r_state == c_ST_IDLE) & w_d_pend;
    assign w_start_inst = (r_state == c_ST_IDLE) & ~w_d_pend & w_i_pend & ~flush_i;

    assign w_data_resp      = (r_state == c_ST_D_WAIT) & bus_data_ok_i;
    assign w_inst_resp      = (r_state == c_ST_I_WAIT) & bus_data_ok_i;
    assign w_inst_keep      = w_inst_resp & ~r_inst_discard & ~flush_i;
    assign w_inst_in_flight = (r_state == c_ST_I_ADDR) | (r_state == c_ST_I_WAIT);

    assign stallreq_from_mem_o = w_d_pend;
    assign stallreq_from_if_o  = w_i_pend;
    assign inst_rdata_o        = r_inst_buf;
    assign data_rdata_o        = r_data_buf;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: data wins in IDLE; requests are held until accepted
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_data) begin
                    w_next_state = c_ST_D_ADDR;
                end else if (w_start_inst) begin
                    w_next_state = c_ST_I_ADDR;
                end
            end
            c_ST_D_ADDR: if (bus_addr_ok_i) w_next_state = c_ST_D_WAIT;
            c_ST_D_WAIT: if (bus_data_ok_i) w_next_state = c_ST_IDLE;
            c_ST_I_ADDR: if (bus_addr_ok_i) w_next_state = c_ST_I_WAIT;
            c_ST_I_WAIT: if (bus_data_ok_i) w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Bus outputs: drive the latched request only while it is being offered
    always_comb begin
        bus_req_o   = 1'b0;
        bus_wr_o    = 1'b0;
        bus_size_o  = 2'b00;
        bus_addr_o  = 32'h0;
        bus_wdata_o = 32'h0;
        bus_wstrb_o = 4'h0;
        if ((r_state == c_ST_D_ADDR) || (r_state == c_ST_I_ADDR)) begin
            bus_req_o   = 1'b1;
            bus_wr_o    = r_wr;
            bus_size_o  = r_size;
            bus_addr_o  = r_addr;
            bus_wdata_o = r_wdata;
            bus_wstrb_o = r_wstrb;
        end
    end

    // Latch request fields at transaction start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
        end else if (w_start_data) begin
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
            r_wstrb <= data_we_i ? data_sel_i : 4'h0;
            r_wr    <= data_we_i;
            r_size  <= data_size_i;
        end else if (w_start_inst) begin
            r_addr  <= inst_addr_i;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
            r_wr    <= 1'b0;
            r_size  <= INST_SIZE;
        end
    end

    // Response capture and done/discard flags; completion beats a same-cycle
    // advance, while a flush always squashes the result it coincides with
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inst_done    <= 1'b0;
            r_data_done    <= 1'b0;
            r_inst_discard <= 1'b0;
            r_inst_buf     <= 32'h0;
            r_data_buf     <= 32'h0;
        end else begin
            if (w_data_resp) begin
                r_data_buf <= bus_rdata_i;
            end
            if (w_data_resp && !flush_i) begin
                r_data_done <= 1'b1;
            end else if (pipe_advance_i || flush_i) begin
                r_data_done <= 1'b0;
            end

            if (w_inst_keep) begin
                r_inst_buf <= bus_rdata_i;
            end
            if (w_inst_keep) begin
                r_inst_done <= 1'b1;
            end else if (pipe_advance_i || flush_i) begin
                r_inst_done <= 1'b0;
            end

            // an in-flight fetch for a squashed PC still finishes on the bus
            if (w_inst_resp) begin
                r_inst_discard <= 1'b0;
            end else if (flush_i && w_inst_in_flight) begin
                r_inst_discard <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_mem;

    // Count stall cycles per port, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_if  <= 32'h0;
            r_perf_mem <= 32'h0;
        end else begin
            if (w_i_pend) r_perf_if  <= r_perf_if + 32'd1;
            if (w_d_pend) r_perf_mem <= r_perf_mem + 32'd1;
        end
    end

    assign perf_if_stall_o  = r_perf_if;
    assign perf_mem_stall_o = r_perf_mem;
`else
    assign perf_if_stall_o  = 32'h0;
    assign perf_mem_stall_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        stall_if;
    logic        data_en;
    logic        data_we;
    logic [3:0]  data_sel;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stall_mem;
    logic        pipe_advance;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic [31:0] perf_if;
    logic [31:0] perf_mem;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.INST_SIZE(2'b10)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .inst_req_i          (inst_req),
        .inst_addr_i         (inst_addr),
        .inst_rdata_o        (inst_rdata),
        .stallreq_from_if_o  (stall_if),
        .data_en_i           (data_en),
        .data_we_i           (data_we),
        .data_sel_i          (data_sel),
        .data_size_i         (data_size),
        .data_addr_i         (data_addr),
        .data_wdata_i        (data_wdata),
        .data_rdata_o        (data_rdata),
        .stallreq_from_mem_o (stall_mem),
        .pipe_advance_i      (pipe_advance),
        .flush_i             (flush),
        .bus_req_o           (bus_req),
        .bus_wr_o            (bus_wr),
        .bus_size_o          (bus_size),
        .bus_addr_o          (bus_addr),
        .bus_wdata_o         (bus_wdata),
        .bus_wstrb_o         (bus_wstrb),
        .bus_addr_ok_i       (bus_addr_ok),
        .bus_data_ok_i       (bus_data_ok),
        .bus_rdata_i         (bus_rdata),
        .perf_if_stall_o     (perf_if),
        .perf_mem_stall_o    (perf_mem)
    );

    // {req, wr, size, wstrb} packed for compact comparisons
    wire [31:0] bus_ctl = {24'h0, bus_req, bus_wr, bus_size, bus_wstrb};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // outputs are observed on the falling edge
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        inst_req     = 1'b0;
        inst_addr    = 32'h0;
        data_en      = 1'b0;
        data_we      = 1'b0;
        data_sel     = 4'h0;
        data_size    = 2'd0;
        data_addr    = 32'h0;
        data_wdata   = 32'h0;
        pipe_advance = 1'b0;
        flush        = 1'b0;
        bus_addr_ok  = 1'b0;
        bus_data_ok  = 1'b0;
        bus_rdata    = 32'h0;
    endtask

    // release held results and return to a quiet pipeline
    task automatic retire();
        inst_req     = 1'b0;
        data_en      = 1'b0;
        bus_data_ok  = 1'b0;
        bus_addr_ok  = 1'b0;
        pipe_advance = 1'b1;
        next_cycle();
        pipe_advance = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // ---------------- reset state ----------------
        settle();
        check("rst_bus_ctl", bus_ctl, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'h0);
        check("rst_stalls", {stall_if, stall_mem}, 32'h0);
        check("rst_perf", perf_if | perf_mem, 32'h0);

        // ---------------- fetch only ----------------
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        settle();
        check("f1_c0_stall_if", stall_if, 32'h1);
        check("f1_c0_bus_req", bus_req, 32'h0);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("f1_c1_bus_ctl", bus_ctl, 32'h80 | 32'h20);
        check("f1_c1_bus_addr", bus_addr, 32'hBFC00000);
        check("f1_c1_stall_if", stall_if, 32'h1);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24010001;
        settle();
        check("f1_c2_bus_req", bus_req, 32'h0);
        check("f1_c2_stall_if", stall_if, 32'h1);
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        // held five cycles with the pipeline stalled elsewhere
        for (int i = 0; i < 5; i++) begin
            settle();
            check("hold_stall_if", stall_if, 32'h0);
            check("hold_bus_req", bus_req, 32'h0);
            check("hold_inst_rdata", inst_rdata, 32'h24010001);
            next_cycle();
        end
        // advance, then the next fetch goes out
        pipe_advance = 1'b1; inst_addr = 32'hBFC00004;
        settle();
        check("adv_stall_if", stall_if, 32'h0);
        next_cycle();
        pipe_advance = 1'b0;
        settle();
        check("adv_next_stall_if", stall_if, 32'h1);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("adv_bus_req", bus_req, 32'h1);
        check("adv_bus_addr", bus_addr, 32'hBFC00004);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("adv_inst_rdata", inst_rdata, 32'h11111111);
        next_cycle();
        retire();

        // ---------------- simultaneous fetch and load ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00010;
        data_en = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_size = 2'd2;
        data_addr = 32'h80000100;
        settle();
        check("sim_c0_stalls", {stall_if, stall_mem}, 32'h3);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("sim_load_bus_ctl", bus_ctl, 32'h80 | 32'h20);
        check("sim_load_bus_addr", bus_addr, 32'h80000100);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE0001;
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("sim_mem_first", {stall_if, stall_mem}, 32'h2);
        check("sim_data_rdata", data_rdata, 32'hCAFE0001);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("sim_fetch_bus_ctl", bus_ctl, 32'h80 | 32'h20);
        check("sim_fetch_bus_addr", bus_addr, 32'hBFC00010);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h22222222;
        settle();
        check("sim_fetch_wait", stall_if, 32'h1);
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("sim_done_stalls", {stall_if, stall_mem}, 32'h0);
        check("sim_inst_rdata", inst_rdata, 32'h22222222);
        next_cycle();
        retire();

        // ---------------- byte store, addr_ok delayed ----------------
        data_en = 1'b1; data_we = 1'b1; data_sel = 4'b0100; data_size = 2'd0;
        data_addr = 32'h80000202; data_wdata = 32'h00AB0000;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = (i == 3);
            if (i == 1) begin
                data_addr = 32'h12345678; data_wdata = 32'hFFFFFFFF; data_sel = 4'hF;
            end
            settle();
            check("st_bus_ctl", bus_ctl, 32'hC4);
            check("st_bus_addr", bus_addr, 32'h80000202);
            check("st_bus_wdata", bus_wdata, 32'h00AB0000);
            next_cycle();
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A5A5A;
        settle();
        check("st_wait_bus_req", bus_req, 32'h0);
        check("st_wait_stall", stall_mem, 32'h1);
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("st_done_stall", stall_mem, 32'h0);
        next_cycle();
        retire();

        // ---------------- flush during I_WAIT ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00020;
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; flush = 1'b1; inst_addr = 32'hBFC00380;
        next_cycle();
        flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
        settle();
        check("fl_wait_stall_if", stall_if, 32'h1);
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        settle();
        check("fl_dropped_rdata", inst_rdata, 32'h22222222);
        check("fl_refetch_stall", stall_if, 32'h1);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("fl_refetch_req", bus_req, 32'h1);
        check("fl_refetch_addr", bus_addr, 32'hBFC00380);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h00000000;
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("fl_new_rdata", inst_rdata, 32'h00000000);
        check("fl_new_stall_if", stall_if, 32'h0);
        next_cycle();
        retire();

        // ---------------- flush and data_ok in the same cycle ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00040;
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; flush = 1'b1; bus_data_ok = 1'b1;
        bus_rdata = 32'h33333333; inst_addr = 32'hBFC00400;
        next_cycle();
        flush = 1'b0; bus_data_ok = 1'b0;
        settle();
        check("fs_dropped_rdata", inst_rdata, 32'h00000000);
        check("fs_stall_if", stall_if, 32'h1);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("fs_refetch_addr", bus_addr, 32'hBFC00400);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h44444444;
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("fs_new_rdata", inst_rdata, 32'h44444444);
        next_cycle();
        retire();

        // ---------------- reset in D_WAIT ----------------
        data_en = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_size = 2'd2;
        data_addr = 32'h80000400;
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("rw_bus_req", bus_req, 32'h1);
        next_cycle();
        bus_addr_ok = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; data_en = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00500;
        settle();
        check("rw_bus_ctl", bus_ctl, 32'h0);
        check("rw_bus_addr", bus_addr, 32'h0);
        check("rw_inst_rdata", inst_rdata, 32'h0);
        check("rw_data_rdata", data_rdata, 32'h0);
        check("rw_stall_mem", stall_mem, 32'h0);
        next_cycle();
        bus_addr_ok = 1'b1;
        settle();
        check("rw_idle_then_fetch", bus_addr, 32'hBFC00500);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55555555;
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();
        retire();

        // ---------------- perf counters: 7 IF stall cycles ----------------
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00600;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            bus_addr_ok = (i == 4);
            next_cycle();
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h66666666;
        next_cycle();
        bus_data_ok = 1'b0;
        settle();
        check("pf_stall_if", stall_if, 32'h0);
        check("pf_inst_rdata", inst_rdata, 32'h66666666);
`ifdef ARB_PERF_EN
        check("pf_if_count", perf_if, 32'd7);
`else
        check("pf_if_count", perf_if, 32'd0);
`endif
        check("pf_mem_count", perf_mem, 32'd0);
        next_cycle();
        retire();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
